// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer for a 3-leg shared mux: grant, hold sel SETTLE cycles, capture into y.
// Latency SETTLE+1 edges from the IDLE edge sampling req to y_vld; level req is held until its ack pulse.
// Define MUX_RR_ARBITER_BURST_EN to chain grants from CAPTURE straight into SELECT without an IDLE cycle.
module mux_rr_arbiter #(
  parameter int W      = 2,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   req,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  output logic [1:0]   sel,
  output logic [2:0]   gnt,
  output logic [W-1:0] y,
  output logic         y_vld,
  output logic [2:0]   ack,
  output logic         busy
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("mux_rr_arbiter: SETTLE must be in the range 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   g_q, g_d;
  logic [1:0]   last_q;
  logic [3:0]   cnt_q, cnt_d;
  logic [2:0]   pick;
  logic [W-1:0] d_g;

  // Returns {found, index} for the first set bit of r scanning base+1, base+2, base+3 (mod 3).
  function automatic logic [2:0] rr_pick(input logic [1:0] base, input logic [2:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 1; i--) begin
      idx = 2'((int'(base) + i) % 3);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    case (g_q)
      2'd0:    d_g = d0;
      2'd1:    d_g = d1;
      default: d_g = d2;
    endcase
  end

  assign pick = rr_pick(last_q, req);

`ifdef MUX_RR_ARBITER_BURST_EN
  logic [2:0] burst_pick;
  // The requester being served is masked so rotation continues from g+1.
  assign burst_pick = rr_pick(g_q, req & ~(3'b001 << g_q));
`endif

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick[2]) begin
          g_d     = pick[1:0];
          cnt_d   = CNT_INIT;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (cnt_q == 4'd0) state_d = CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE: begin
`ifdef MUX_RR_ARBITER_BURST_EN
        if (burst_pick[2]) begin
          g_d     = burst_pick[1:0];
          cnt_d   = CNT_INIT;
          state_d = SELECT;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= 2'd0;
      cnt_q   <= 4'd0;
      last_q  <= 2'd2;
      y       <= '0;
      y_vld   <= 1'b0;
      ack     <= 3'b000;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      y_vld   <= (state_q == CAPTURE);
      ack     <= (state_q == CAPTURE) ? (3'b001 << g_q) : 3'b000;
      if (state_q == CAPTURE) begin
        y      <= d_g;
        last_q <= g_q;
      end
    end
  end

  // Pure decode of flopped state and grant index: no path from req to any output.
  assign busy = (state_q != IDLE);
  assign sel  = busy ? g_q : 2'd3;
  assign gnt  = busy ? (3'b001 << g_q) : 3'b000;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: transaction-level countdown model compared every cycle, plus literal scenarios.
module tb_mux_rr_arbiter;

  localparam int W      = 2;
  localparam int SETTLE = 1;

  logic         clk;
  logic         rst_n;
  logic [2:0]   req;
  logic [W-1:0] d0, d1, d2;
  logic [1:0]   sel;
  logic [2:0]   gnt;
  logic [W-1:0] y;
  logic         y_vld;
  logic [2:0]   ack;
  logic         busy;

  logic [2:0]   req4;
  logic [W-1:0] e0, e1, e2;
  logic [1:0]   sel4;
  logic [2:0]   gnt4;
  logic [W-1:0] y4;
  logic         y_vld4;
  logic [2:0]   ack4;
  logic         busy4;

  int checks   = 0;
  int failures = 0;

  mux_rr_arbiter #(.W(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .d0(d0), .d1(d1), .d2(d2),
    .sel(sel), .gnt(gnt), .y(y), .y_vld(y_vld), .ack(ack), .busy(busy)
  );

  mux_rr_arbiter #(.W(W), .SETTLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .d0(e0), .d1(e1), .d2(e2),
    .sel(sel4), .gnt(gnt4), .y(y4), .y_vld(y_vld4), .ack(ack4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transaction occupies SETTLE+1 cycles (select + capture); 0 means idle.
  int           m_left;
  int           m_g;
  int           m_last;
  logic [W-1:0] m_y;
  logic         m_vld;
  logic [2:0]   m_ack;

  function automatic logic [W-1:0] leg(input int i);
    if (i == 0) return d0;
    if (i == 1) return d1;
    return d2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int  k;
    bit  found;
    if (!rst_n) begin
      m_left = 0; m_g = 0; m_last = 2; m_y = '0; m_vld = 1'b0; m_ack = 3'b000;
    end else begin
      m_vld = 1'b0;
      m_ack = 3'b000;
      if (m_left == 0) begin
        found = 0;
        for (int i = 1; i <= 3; i++) begin
          k = (m_last + i) % 3;
          if (!found && req[k]) begin found = 1; m_g = k; end
        end
        if (found) m_left = SETTLE + 1;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_y    = leg(m_g);
          m_vld  = 1'b1;
          m_ack  = 3'b001 << m_g;
          m_last = m_g;
`ifdef MUX_RR_ARBITER_BURST_EN
          found = 0;
          for (int i = 1; i <= 2; i++) begin
            k = (m_last + i) % 3;
            if (!found && req[k]) begin found = 1; m_g = k; end
          end
          if (found) m_left = SETTLE + 1;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("model_busy",  32'(busy),  32'(m_left != 0));
      chk("model_sel",   32'(sel),   (m_left != 0) ? m_g : 3);
      chk("model_gnt",   32'(gnt),   (m_left != 0) ? (32'd1 << m_g) : 32'd0);
      chk("model_y",     32'(y),     32'(m_y));
      chk("model_y_vld", 32'(y_vld), 32'(m_vld));
      chk("model_ack",   32'(ack),   32'(m_ack));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 3'b000; req4 = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a y_vld cycle; n returns the number of negedges waited.
  task automatic wait_vld(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (y_vld !== 1'b1 && n < 20);
    if (y_vld !== 1'b1) chk({nm, "_timeout"}, 32'(y_vld), 32'd1);
  endtask

  int n;
  int exp_gap;
  logic [W-1:0] exp_y   [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
  logic [2:0]   exp_ack [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    rst_n = 1'b0; req = 3'b000; req4 = 3'b000;
    d0 = '0; d1 = '0; d2 = '0; e0 = '0; e1 = '0; e2 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset release.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_sel",   32'(sel),   32'd3);
      chk("idle_gnt",   32'(gnt),   32'd0);
      chk("idle_busy",  32'(busy),  32'd0);
      chk("idle_y",     32'(y),     32'd0);
      chk("idle_y_vld", 32'(y_vld), 32'd0);
      chk("idle4_busy", 32'(busy4), 32'd0);
    end

    // SETTLE=4: d2 changes during the second SELECT cycle; capture must see the new value.
    req4 = 3'b100; e2 = 2'd0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 5) begin
        chk("s4_busy",  32'(busy4),  32'd1);
        chk("s4_gnt",   32'(gnt4),   32'b100);
        chk("s4_sel",   32'(sel4),   32'd2);
        chk("s4_y_vld", 32'(y_vld4), 32'd0);
      end else begin
        chk("s4_y_vld_hit", 32'(y_vld4), 32'd1);
        chk("s4_y",         32'(y4),     32'd3);
        chk("s4_ack",       32'(ack4),   32'b100);
        chk("s4_sel_after", 32'(sel4),   32'd3);
        req4 = 3'b000;
      end
      if (c == 2) e2 = 2'd3;
    end
    @(negedge clk);
    chk("s4_y_vld_clear", 32'(y_vld4), 32'd0);
    chk("s4_y_hold",      32'(y4),     32'd3);

    // Single request from requester 0, SETTLE=1.
    req = 3'b001; d0 = 2'b10;
    @(negedge clk);
    chk("single_gnt1",  32'(gnt),  32'b001);
    chk("single_busy1", 32'(busy), 32'd1);
    chk("single_sel1",  32'(sel),  32'd0);
    @(negedge clk);
    chk("single_gnt2",  32'(gnt),   32'b001);
    chk("single_vld2",  32'(y_vld), 32'd0);
    @(negedge clk);
    chk("single_y",     32'(y),     32'b10);
    chk("single_vld3",  32'(y_vld), 32'd1);
    chk("single_ack3",  32'(ack),   32'b001);
    chk("single_sel3",  32'(sel),   32'd3);
    req = 3'b000;
    @(negedge clk);
    chk("single_vld4",  32'(y_vld), 32'd0);
    chk("single_ack4",  32'(ack),   32'd0);
    chk("single_yhold", 32'(y),     32'b10);

    // All three requesting from reset: strict rotation 0,1,2,0.
    do_reset();
    req = 3'b111; d0 = 2'd1; d1 = 2'd2; d2 = 2'd3;
`ifdef MUX_RR_ARBITER_BURST_EN
    exp_gap = SETTLE + 1;
`else
    exp_gap = SETTLE + 2;
`endif
    for (int k = 0; k < 4; k++) begin
      wait_vld("rot_wait", n);
      chk("rot_y",   32'(y),   32'(exp_y[k]));
      chk("rot_ack", 32'(ack), 32'(exp_ack[k]));
      chk("rot_gap", n, (k == 0) ? SETTLE + 2 : exp_gap);
    end
    req = 3'b000;
    repeat (4) @(negedge clk);

    // One-cycle pulse on requester 1 still completes and acks.
    req = 3'b010;
    @(negedge clk);
    req = 3'b000;
    wait_vld("pulse_wait", n);
    chk("pulse_ack", 32'(ack), 32'b010);
    chk("pulse_y",   32'(y),   32'd2);

    // Async reset during SELECT: outputs clear before the next edge, no ack, rotation restarts at 0.
    repeat (2) @(negedge clk);
    req = 3'b100;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sel",  32'(sel),  32'd3);
    chk("arst_gnt",  32'(gnt),  32'd0);
    chk("arst_y",    32'(y),    32'd0);
    chk("arst_ack",  32'(ack),  32'd0);
    @(negedge clk);
    rst_n = 1'b1; req = 3'b111;
    @(negedge clk);
    chk("arst_first_gnt", 32'(gnt), 32'b001);
    req = 3'b001;
    wait_vld("arst_wait", n);
    chk("arst_ack_after", 32'(ack), 32'b001);
    req = 3'b000;
    repeat (3) @(negedge clk);

    // Random requesters: hold until ack, occasional early drop, random data, rare async reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (req[i]) begin
          if (ack[i])                          req[i] = ($urandom_range(0, 3) == 0);
          else if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
      end
      d0 = W'($urandom); d1 = W'($urandom); d2 = W'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #1 rst_n = 1'b0;
        #1 chk("rand_arst_busy", 32'(busy), 32'd0);
        #1 rst_n = 1'b1;
      end
    end
    req = 3'b000;
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
